// File: rtl/riscv_csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, the
// CSR instruction op encoding, mstatus bit positions and the mstatus
// default value (MPP = 2'b11).
package riscv_csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] CSR_MSTATUS_DEFAULT = 64'h0000_000a_0000_1800;

endpackage

// File: rtl/riscv_csr_file_if.sv
// CSR access bus between the write-back unit (master) and the CSR file
// (slave).
//   csr_op_i     : 00 none, 01 RW, 10 RS, 11 RC
//   csr_addr_i   : CSR address, read every cycle, op target when op != 0
//   csr_wdata_i  : operand (rs1 or zero-extended zimm)
//   csr_rdata_o  : pre-write value of csr_addr_i (0 when unimplemented)
//   csr_illegal_o: op issued to an unimplemented address
// Handshake: there is no ready. A non-zero csr_op_i is a request that is
// always accepted in the cycle it is presented; rdata/illegal answer in the
// same cycle and the write commits on the next rising clock edge.
interface riscv_csr_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
);
  logic [1:0]            csr_op_i;
  logic [ADDR_WIDTH-1:0] csr_addr_i;
  logic [DATA_WIDTH-1:0] csr_wdata_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  csr_illegal_o;

  modport master (
    output csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/riscv_csr_file_dff.sv
// Storage primitives for the CSR file.
//   riscv_dff         : enabled register with async active-low reset.
//                       ports clk, rst_n, en, d, q.
//   riscv_csr_counter : free-running counter; a software write (wen/din)
//                       replaces the increment for that cycle.
//                       ports clk, rst_n, inc, wen, din, q.
module riscv_dff #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module riscv_csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         wen,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  logic [W-1:0] d;

  // Wraps naturally from all-ones to zero.
  assign d = wen ? din : (q + W'(inc));

  riscv_dff #(.W(W), .RST('0)) u_q (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(d), .q(q)
  );
endmodule

// File: rtl/riscv_csr_file.sv
// Machine-mode CSR file: mstatus, mtvec, mepc, mcause, mscratch and optional
// mcycle/minstret. Executes RW/RS/RC ops from the CSR bus, updates state on
// trap entry and mret, and produces the redirect target.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   csr_bus (slave)                 : CSR op/addr/wdata in, rdata/illegal out
//   trap_valid_i/trap_pc_i/trap_cause_i : trap entry this cycle
//   mret_valid_i                    : mret retiring this cycle
//   instret_i                       : one instruction retired this cycle
//   redirect_pc_o/redirect_valid_o  : trap vector or mepc, same cycle
//   mstatus_o, mepc_o, mtvec_o      : direct register taps
module riscv_csr_file
  import riscv_csr_file_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    ADDR_WIDTH    = 12,
  parameter logic [DATA_WIDTH-1:0] MSTATUS_RESET = DATA_WIDTH'(CSR_MSTATUS_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET   = '0,
  parameter bit                    HAS_COUNTERS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_csr_file_if.slave       csr_bus,
  input  logic                  trap_valid_i,
  input  logic [DATA_WIDTH-1:0] trap_pc_i,
  input  logic [DATA_WIDTH-1:0] trap_cause_i,
  input  logic                  mret_valid_i,
  input  logic                  instret_i,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] mstatus_o,
  output logic [DATA_WIDTH-1:0] mepc_o,
  output logic [DATA_WIDTH-1:0] mtvec_o
);
  localparam int DW = DATA_WIDTH;

  csr_op_e       op;
  logic          op_active;
  logic          sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause;
  logic          sel_mcycle, sel_minstret, addr_ok, sw_wen;
  logic [DW-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [DW-1:0] mcycle_q, minstret_q;
  logic [DW-1:0] rdata, wval, mstatus_d, mtvec_base;
  logic          unused_pc_lsb;

  assign op        = csr_op_e'(csr_bus.csr_op_i);
  assign op_active = (op != CSR_OP_NONE);

  // Address decode; counters only exist when HAS_COUNTERS is set.
  assign sel_mstatus  = (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MSTATUS));
  assign sel_mtvec    = (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MTVEC));
  assign sel_mscratch = (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MSCRATCH));
  assign sel_mepc     = (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MEPC));
  assign sel_mcause   = (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MCAUSE));
  assign sel_mcycle   = HAS_COUNTERS && (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MCYCLE));
  assign sel_minstret = HAS_COUNTERS && (csr_bus.csr_addr_i == ADDR_WIDTH'(CSR_MINSTRET));
  assign addr_ok = sel_mstatus | sel_mtvec | sel_mscratch | sel_mepc |
                   sel_mcause | sel_mcycle | sel_minstret;

  always_comb begin
    rdata = '0;
    if (sel_mstatus)  rdata = mstatus_q;
    if (sel_mtvec)    rdata = mtvec_q;
    if (sel_mscratch) rdata = mscratch_q;
    if (sel_mepc)     rdata = mepc_q;
    if (sel_mcause)   rdata = mcause_q;
    if (sel_mcycle)   rdata = mcycle_q;
    if (sel_minstret) rdata = minstret_q;
  end

  assign csr_bus.csr_rdata_o   = rdata;
  assign csr_bus.csr_illegal_o = op_active & ~addr_ok;

  always_comb begin
    case (op)
      CSR_OP_RW: wval = csr_bus.csr_wdata_i;
      CSR_OP_RS: wval = rdata | csr_bus.csr_wdata_i;
      CSR_OP_RC: wval = rdata & ~csr_bus.csr_wdata_i;
      default:   wval = rdata;
    endcase
  end

  // Trap and mret outrank software writes; a losing write is dropped whole.
  assign sw_wen = op_active & addr_ok & ~trap_valid_i & ~mret_valid_i;

  // Only MIE and MPIE are stored from software; everything else is rebuilt
  // from the reset value with MPP pinned to machine mode.
  always_comb begin
    mstatus_d = mstatus_q;
    if (trap_valid_i) begin
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
    end else if (mret_valid_i) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end else if (sw_wen && sel_mstatus) begin
      mstatus_d = MSTATUS_RESET;
      mstatus_d[MSTATUS_MIE]  = wval[MSTATUS_MIE];
      mstatus_d[MSTATUS_MPIE] = wval[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
  end

  riscv_dff #(.W(DW), .RST(MSTATUS_RESET)) u_mstatus (
    .clk(clk), .rst_n(rst_n),
    .en(trap_valid_i | mret_valid_i | (sw_wen & sel_mstatus)),
    .d(mstatus_d), .q(mstatus_q)
  );

  // Reserved mtvec modes 2/3 collapse to direct mode.
  riscv_dff #(.W(DW), .RST(MTVEC_RESET)) u_mtvec (
    .clk(clk), .rst_n(rst_n), .en(sw_wen & sel_mtvec),
    .d({wval[DW-1:2], wval[1] ? 2'b00 : wval[1:0]}), .q(mtvec_q)
  );

  riscv_dff #(.W(DW), .RST('0)) u_mscratch (
    .clk(clk), .rst_n(rst_n), .en(sw_wen & sel_mscratch),
    .d(wval), .q(mscratch_q)
  );

  riscv_dff #(.W(DW), .RST('0)) u_mepc (
    .clk(clk), .rst_n(rst_n), .en(trap_valid_i | (sw_wen & sel_mepc)),
    .d(trap_valid_i ? {trap_pc_i[DW-1:2], 2'b00} : {wval[DW-1:2], 2'b00}),
    .q(mepc_q)
  );

  riscv_dff #(.W(DW), .RST('0)) u_mcause (
    .clk(clk), .rst_n(rst_n), .en(trap_valid_i | (sw_wen & sel_mcause)),
    .d(trap_valid_i ? trap_cause_i : wval), .q(mcause_q)
  );

  assign unused_pc_lsb = ^trap_pc_i[1:0];

  generate
    if (HAS_COUNTERS) begin : g_counters
      riscv_csr_counter #(.W(DW)) u_mcycle (
        .clk(clk), .rst_n(rst_n), .inc(1'b1),
        .wen(sw_wen & sel_mcycle), .din(wval), .q(mcycle_q)
      );
      riscv_csr_counter #(.W(DW)) u_minstret (
        .clk(clk), .rst_n(rst_n), .inc(instret_i),
        .wen(sw_wen & sel_minstret), .din(wval), .q(minstret_q)
      );
    end else begin : g_no_counters
      logic unused_instret;
      assign unused_instret = instret_i;
      assign mcycle_q       = '0;
      assign minstret_q     = '0;
    end
  endgenerate

  // Vectored mode adds 4*cause only for interrupts (cause MSB set);
  // 4*cause[DW-2:0] modulo 2^DW is cause[DW-3:0] shifted by two.
  assign mtvec_base = {mtvec_q[DW-1:2], 2'b00};

  always_comb begin
    redirect_pc_o = '0;
    if (trap_valid_i) begin
      if (mtvec_q[1:0] == 2'b01 && trap_cause_i[DW-1]) begin
        redirect_pc_o = mtvec_base + {trap_cause_i[DW-3:0], 2'b00};
      end else begin
        redirect_pc_o = mtvec_base;
      end
    end else if (mret_valid_i) begin
      redirect_pc_o = mepc_q;
    end
  end

  assign redirect_valid_o = trap_valid_i | mret_valid_i;
  assign mstatus_o        = mstatus_q;
  assign mepc_o           = mepc_q;
  assign mtvec_o          = mtvec_q;

endmodule

// File: tb/tb_riscv_csr_file.sv
module tb_riscv_csr_file;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam logic [63:0] MS_BASE = 64'h0000_000a_0000_1800;
  localparam logic [63:0] ONES    = {64{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  riscv_csr_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  riscv_csr_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  logic          trap_valid, mret_valid, instret;
  logic [DW-1:0] trap_pc, trap_cause;
  logic [DW-1:0] redirect_pc, mstatus_v, mepc_v, mtvec_v;
  logic [DW-1:0] redirect_pc2, mstatus_v2, mepc_v2, mtvec_v2;
  logic          redirect_valid, redirect_valid2;

  assign bus2.csr_op_i    = bus.csr_op_i;
  assign bus2.csr_addr_i  = bus.csr_addr_i;
  assign bus2.csr_wdata_i = bus.csr_wdata_i;

  riscv_csr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HAS_COUNTERS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .csr_bus(bus),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause),
    .mret_valid_i(mret_valid), .instret_i(instret),
    .redirect_pc_o(redirect_pc), .redirect_valid_o(redirect_valid),
    .mstatus_o(mstatus_v), .mepc_o(mepc_v), .mtvec_o(mtvec_v)
  );

  riscv_csr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HAS_COUNTERS(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .csr_bus(bus2),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause),
    .mret_valid_i(mret_valid), .instret_i(instret),
    .redirect_pc_o(redirect_pc2), .redirect_valid_o(redirect_valid2),
    .mstatus_o(mstatus_v2), .mepc_o(mepc_v2), .mtvec_o(mtvec_v2)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_mie, m_mpie;
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mscratch, m_mcycle, m_minstret;
  logic [63:0] m_nv;

  function automatic bit m_legal(input logic [11:0] a, input bit hc);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
      12'hB00, 12'hB02: return hc;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a, input bit hc);
    case (a)
      12'h300: return MS_BASE | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return hc ? m_mcycle : 64'd0;
      12'hB02: return hc ? m_minstret : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_apply(input logic [1:0] o, input logic [63:0] old,
                                          input logic [63:0] d);
    case (o)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  function automatic logic [63:0] m_redirect();
    logic [63:0] base;
    base = m_mtvec & ~64'h3;
    if (trap_valid) begin
      if (m_mtvec[1:0] == 2'b01 && trap_cause[63])
        return base + (trap_cause & ~(64'h1 << 63)) * 64'd4;
      return base;
    end
    return m_mepc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie <= 1'b0; m_mpie <= 1'b0;
      m_mtvec <= '0; m_mepc <= '0; m_mcause <= '0; m_mscratch <= '0;
      m_mcycle <= '0; m_minstret <= '0;
    end else begin
      m_mcycle   <= m_mcycle + 64'd1;
      m_minstret <= m_minstret + 64'(instret);
      if (trap_valid) begin
        m_mepc   <= trap_pc & ~64'h3;
        m_mcause <= trap_cause;
        m_mpie   <= m_mie;
        m_mie    <= 1'b0;
      end else if (mret_valid) begin
        m_mie  <= m_mpie;
        m_mpie <= 1'b1;
      end else if (bus.csr_op_i != 2'b00 && m_legal(bus.csr_addr_i, 1'b1)) begin
        case (bus.csr_addr_i)
          12'h300: begin m_mie <= m_nv[3]; m_mpie <= m_nv[7]; end
          12'h305: m_mtvec    <= (m_nv[1:0] >= 2'd2) ? (m_nv & ~64'h3) : m_nv;
          12'h340: m_mscratch <= m_nv;
          12'h341: m_mepc     <= m_nv & ~64'h3;
          12'h342: m_mcause   <= m_nv;
          12'hB00: m_mcycle   <= m_nv;
          12'hB02: m_minstret <= m_nv;
          default: ;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    m_nv = m_apply(bus.csr_op_i, m_read(bus.csr_addr_i, 1'b1), bus.csr_wdata_i);
    if (rst_n) begin
      check("rdata", bus.csr_rdata_o, m_read(bus.csr_addr_i, 1'b1));
      check("illegal", 64'(bus.csr_illegal_o),
            64'(bus.csr_op_i != 2'b00 && !m_legal(bus.csr_addr_i, 1'b1)));
      check("redirect_valid", 64'(redirect_valid), 64'(trap_valid | mret_valid));
      if (trap_valid | mret_valid) check("redirect_pc", redirect_pc, m_redirect());
      check("mstatus_o", mstatus_v, m_read(12'h300, 1'b1));
      check("mepc_o", mepc_v, m_mepc);
      check("mtvec_o", mtvec_v, m_mtvec);
      check("nc_rdata", bus2.csr_rdata_o, m_read(bus.csr_addr_i, 1'b0));
      check("nc_illegal", 64'(bus2.csr_illegal_o),
            64'(bus.csr_op_i != 2'b00 && !m_legal(bus.csr_addr_i, 1'b0)));
      check("nc_redirect_valid", 64'(redirect_valid2), 64'(trap_valid | mret_valid));
      if (trap_valid | mret_valid) check("nc_redirect_pc", redirect_pc2, m_redirect());
      check("nc_mstatus_o", mstatus_v2, m_read(12'h300, 1'b0));
      check("nc_mepc_o", mepc_v2, m_mepc);
      check("nc_mtvec_o", mtvec_v2, m_mtvec);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.csr_op_i = 2'b00; bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
    trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
    mret_valid = 1'b0; instret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [63:0] d);
    bus.csr_op_i = o; bus.csr_addr_i = a; bus.csr_wdata_i = d;
  endtask

  task automatic trap(input logic [63:0] pc, input logic [63:0] cause);
    trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    csr(2'b00, 12'hB00, '0);
    @(negedge clk);
    check("rst_mstatus", mstatus_v, 64'h0000_000a_0000_1800);
    check("rst_mtvec", mtvec_v, 64'h0);
    check("rst_mepc", mepc_v, 64'h0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'h0);
    check("rst_mcycle", bus.csr_rdata_o, 64'h0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("mcycle_after_rst", bus.csr_rdata_o, 64'(i));
    end
    tick();

    // mscratch read-modify-write sequence
    csr(2'b01, 12'h340, 64'hF0); @(negedge clk); check("rw_old", bus.csr_rdata_o, 64'h0);  tick();
    csr(2'b10, 12'h340, 64'h0F); @(negedge clk); check("rs_old", bus.csr_rdata_o, 64'hF0); tick();
    csr(2'b11, 12'h340, 64'h3C); @(negedge clk); check("rc_old", bus.csr_rdata_o, 64'hFF); tick();
    csr(2'b00, 12'h340, 64'h0);  @(negedge clk); check("rc_new", bus.csr_rdata_o, 64'hC3); tick();

    // mstatus WARL
    csr(2'b01, 12'h300, ONES);  @(negedge clk); tick();
    csr(2'b00, 12'h300, 64'h0); @(negedge clk); check("mstatus_ones", bus.csr_rdata_o, 64'h0000_000a_0000_1888); tick();
    csr(2'b11, 12'h300, 64'h80); @(negedge clk); tick();
    @(negedge clk); check("mstatus_rc", mstatus_v, 64'h0000_000a_0000_1808); tick();

    // vectored interrupt trap, then mret
    csr(2'b01, 12'h305, 64'h8000_0001); @(negedge clk); tick();
    trap(64'h1237, 64'h8000_0000_0000_0007);
    @(negedge clk);
    check("trap_redirect_valid", 64'(redirect_valid), 64'h1);
    check("trap_vector", redirect_pc, 64'h8000_001C);
    tick();
    csr(2'b00, 12'h342, 64'h0);
    @(negedge clk);
    check("trap_mepc", mepc_v, 64'h1234);
    check("trap_mstatus", mstatus_v, 64'h0000_000a_0000_1880);
    check("trap_mcause", bus.csr_rdata_o, 64'h8000_0000_0000_0007);
    tick();
    mret_valid = 1'b1;
    @(negedge clk); check("mret_target", redirect_pc, 64'h1234); tick();
    @(negedge clk); check("mret_mstatus", mstatus_v, 64'h0000_000a_0000_1888); tick();

    // trap beats a same-cycle mepc write; exception in vectored mode uses base
    csr(2'b01, 12'h341, 64'h1234); trap(64'h4000_0002, 64'h2);
    @(negedge clk); check("exc_vector", redirect_pc, 64'h8000_0000); tick();
    @(negedge clk); check("trap_over_write", mepc_v, 64'h4000_0000); tick();

    // mret beats a same-cycle mscratch write
    csr(2'b01, 12'h340, 64'hDEAD); mret_valid = 1'b1;
    @(negedge clk); check("mret_target2", redirect_pc, 64'h4000_0000); tick();
    csr(2'b00, 12'h340, 64'h0);
    @(negedge clk); check("mret_over_write", bus.csr_rdata_o, 64'hC3); tick();

    // mtvec and mepc legalisation
    csr(2'b01, 12'h305, 64'h103); @(negedge clk); tick();
    @(negedge clk); check("mtvec_mode3", mtvec_v, 64'h100); tick();
    csr(2'b01, 12'h305, 64'h102); @(negedge clk); tick();
    @(negedge clk); check("mtvec_mode2", mtvec_v, 64'h100); tick();
    csr(2'b01, 12'h341, 64'h7); @(negedge clk); tick();
    @(negedge clk); check("mepc_align", mepc_v, 64'h4); tick();

    // direct mode ignores interrupt cause for the vector
    trap(64'h88, 64'h8000_0000_0000_0005);
    @(negedge clk); check("direct_vector", redirect_pc, 64'h100); tick();

    // counter write override and wrap
    csr(2'b01, 12'hB02, ONES); instret = 1'b1; @(negedge clk); tick();
    csr(2'b00, 12'hB02, 64'h0); instret = 1'b1;
    @(negedge clk); check("minstret_ones", bus.csr_rdata_o, ONES); tick();
    csr(2'b00, 12'hB02, 64'h0);
    @(negedge clk); check("minstret_wrap", bus.csr_rdata_o, 64'h0); tick();
    csr(2'b01, 12'hB00, 64'h5); @(negedge clk); tick();
    csr(2'b00, 12'hB00, 64'h0);
    @(negedge clk); check("mcycle_w5", bus.csr_rdata_o, 64'h5);
    @(negedge clk); check("mcycle_w6", bus.csr_rdata_o, 64'h6);
    tick();

    // illegal addresses
    csr(2'b10, 12'h7C0, 64'hFF);
    @(negedge clk);
    check("illegal_7c0", 64'(bus.csr_illegal_o), 64'h1);
    check("illegal_rdata", bus.csr_rdata_o, 64'h0);
    tick();
    csr(2'b00, 12'h7C0, 64'h0);
    @(negedge clk); check("no_op_not_illegal", 64'(bus.csr_illegal_o), 64'h0); tick();
    csr(2'b01, 12'hB00, 64'h77);
    @(negedge clk);
    check("nc_counter_illegal", 64'(bus2.csr_illegal_o), 64'h1);
    check("counter_legal", 64'(bus.csr_illegal_o), 64'h0);
    tick();
    csr(2'b00, 12'hB00, 64'h0);
    @(negedge clk); check("mcycle_w77", bus.csr_rdata_o, 64'h77);

    // asynchronous reset mid-run
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_mstatus", mstatus_v, 64'h0000_000a_0000_1800);
    check("mid_rst_mtvec", mtvec_v, 64'h0);
    check("mid_rst_mepc", mepc_v, 64'h0);
    check("mid_rst_mcycle", bus.csr_rdata_o, 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("mcycle_after_mid_rst", bus.csr_rdata_o, 64'(i));
    end
    tick();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
